// File: rtl/sync_feeder_if.sv
// Bundle of the upstream stream, downstream stream and synchroniser strobes around sync_feeder.
// The master modport is the feeder's view; the slave modport is the surrounding logic's view.
interface sync_feeder_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic          out_last;

  logic          sy_en;
  logic          sy_wr;
  logic          sy_rd;
  logic [DW-1:0] sy_dina;
  logic [DW-1:0] sy_dinb;
  logic [DW-1:0] sy_douta;
  logic [DW-1:0] sy_doutb;
  logic          sy_rdy;

  logic          err;

  modport master (
    input  in_valid, in_a, in_b, out_ready, sy_douta, sy_doutb, sy_rdy,
    output in_ready, out_valid, out_a, out_b, out_last,
           sy_en, sy_wr, sy_rd, sy_dina, sy_dinb, err
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, sy_douta, sy_doutb, sy_rdy,
    input  in_ready, out_valid, out_a, out_b, out_last,
           sy_en, sy_wr, sy_rd, sy_dina, sy_dinb, err
  );
endinterface

// File: rtl/sync_feeder.sv
// Initiator-side controller for the dual-FIFO matrix synchroniser: loads a 3x3 A/B tile pair,
// reads the nine pairs back and streams them downstream with a last flag.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | sy_en low, waiting for upstream in_valid
// S_START  | sy_en high, waiting for sy_rdy with timeout
// S_LD_ACC | write slot start, in_ready high until a beat is accepted
// S_LD_WR  | sy_wr high for OP_HOLD cycles, data stable
// S_LD_GAP | sy_wr low gap cycle, wcnt advances
// S_DRAIN  | sy_rd high for OP_HOLD cycles
// S_SAMPLE | capture synchroniser outputs into out_a/out_b
// S_OUT    | out_valid held until out_ready
// S_DONE   | sy_en low for two cycles between tiles
module sync_feeder #(
  parameter int DW      = 16,
  parameter int N       = 9,
  parameter int OP_HOLD = 2,
  parameter int TMO     = 15
) (
  input  logic          clk,
  input  logic          rst,
  sync_feeder_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_LD_ACC,
    S_LD_WR,
    S_LD_GAP,
    S_DRAIN,
    S_SAMPLE,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [3:0] N_C     = 4'(N);
  localparam logic [3:0] LAST_C  = 4'(N - 1);
  localparam logic [3:0] TMO_LD  = 4'(TMO - 1);
  localparam logic [3:0] HOLD_LD = 4'(OP_HOLD - 1);
  localparam logic [3:0] DONE_LD = 4'd1;

  state_t        state_q, state_d;
  logic [3:0]    tmr_q, tmr_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [3:0]    rcnt_q, rcnt_d;
  logic [DW-1:0] dina_q, dina_d;
  logic [DW-1:0] dinb_q, dinb_d;
  logic [DW-1:0] out_a_q, out_a_d;
  logic [DW-1:0] out_b_q, out_b_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          err_q, err_d;

  logic          tmr_tc;
  logic [3:0]    wcnt_inc;
  logic [3:0]    rcnt_inc;

  assign tmr_tc   = (tmr_q == 4'd0);
  assign wcnt_inc = wcnt_q + 4'd1;
  assign rcnt_inc = rcnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      dina_q      <= '0;
      dinb_q      <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      dina_q      <= dina_d;
      dinb_q      <= dinb_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  // Next state and the shared down-counter used as wait timer, hold timer and DONE timer.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_START;
          tmr_d   = TMO_LD;
        end
      end
      S_START: begin
        if (bus.sy_rdy) begin
          state_d = S_LD_ACC;
        end else if (tmr_tc) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - 4'd1;
        end
      end
      S_LD_ACC: begin
        if (bus.in_valid) begin
          state_d = S_LD_WR;
          tmr_d   = HOLD_LD;
        end
      end
      S_LD_WR: begin
        if (tmr_tc) state_d = S_LD_GAP;
        else        tmr_d   = tmr_q - 4'd1;
      end
      S_LD_GAP: begin
        if (wcnt_inc == N_C) begin
          state_d = S_DRAIN;
          tmr_d   = HOLD_LD;
        end else begin
          state_d = S_LD_ACC;
        end
      end
      S_DRAIN: begin
        if (tmr_tc) state_d = S_SAMPLE;
        else        tmr_d   = tmr_q - 4'd1;
      end
      S_SAMPLE: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          if (rcnt_inc == N_C) begin
            state_d = S_DONE;
            tmr_d   = DONE_LD;
          end else begin
            state_d = S_DRAIN;
            tmr_d   = HOLD_LD;
          end
        end
      end
      S_DONE: begin
        // A waiting upstream tile goes straight to START so tiles are separated by exactly two sy_en-low cycles.
        if (tmr_tc) begin
          if (bus.in_valid) begin
            state_d = S_START;
            tmr_d   = TMO_LD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tmr_d = tmr_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_comb begin
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    dina_d      = dina_q;
    dinb_d      = dinb_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    unique case (state_q)
      S_START: begin
        if (!bus.sy_rdy && tmr_tc) err_d = 1'b1;
      end
      S_LD_ACC: begin
        if (bus.in_valid) begin
          dina_d = bus.in_a;
          dinb_d = bus.in_b;
        end
      end
      S_LD_GAP: begin
        wcnt_d = wcnt_inc;
      end
      S_SAMPLE: begin
        out_a_d     = bus.sy_douta;
        out_b_d     = bus.sy_doutb;
        out_valid_d = 1'b1;
        out_last_d  = (rcnt_q == LAST_C);
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          rcnt_d      = rcnt_inc;
        end
      end
      S_DONE: begin
        if (tmr_tc) begin
          wcnt_d = '0;
          rcnt_d = '0;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    bus.sy_en    = 1'b0;
    bus.sy_wr    = 1'b0;
    bus.sy_rd    = 1'b0;
    bus.in_ready = 1'b0;
    unique case (state_q)
      S_START:  bus.sy_en = 1'b1;
      S_LD_ACC: begin
        bus.sy_en    = 1'b1;
        bus.in_ready = 1'b1;
      end
      S_LD_WR: begin
        bus.sy_en = 1'b1;
        bus.sy_wr = 1'b1;
      end
      S_LD_GAP: bus.sy_en = 1'b1;
      S_DRAIN: begin
        bus.sy_en = 1'b1;
        bus.sy_rd = 1'b1;
      end
      S_SAMPLE: bus.sy_en = 1'b1;
      S_OUT:    bus.sy_en = 1'b1;
      default: begin
      end
    endcase
  end

  assign bus.sy_dina   = dina_q;
  assign bus.sy_dinb   = dinb_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.err       = err_q;

endmodule
